// File: rtl/dbg_view_ctrl.sv
// Debug inspection controller: halts the CPU, reads a switch-selected memory word
// and scans it onto a 4-digit seven-segment display. Optional single-step: DBG_STEP_EN.
module dbg_view_ctrl #(
    parameter int unsigned AW       = 7,
    parameter int unsigned READ_LAT = 1,
    parameter int unsigned SCAN_W   = 16
) (
    input  logic          clk,
    input  logic          rst_n,
`ifdef DBG_STEP_EN
    input  logic          step,
`endif
    input  logic          dbg_en,
    input  logic [AW-1:0] dbg_addr,
    input  logic          dbg_half,
    input  logic [AW-1:0] cpu_addr,
    input  logic          cpu_idle,
    input  logic [15:0]   cpu_disp,
    output logic          cpu_halt,
    output logic [AW-1:0] mem_addr,
    input  logic [31:0]   mem_rdata,
    output logic [3:0]    an,
    output logic [7:0]    seg
);

    localparam int unsigned LW = 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRAIN,
        S_READ,
        S_HOLD
    } state_t;

    state_t          state_q, state_d;
    logic            halt_q, halt_d;
    logic [AW-1:0]   cap_addr_q, cap_addr_d;
    logic [LW-1:0]   lat_q, lat_d;
    logic [31:0]     word_q, word_d;
    logic [SCAN_W-1:0] scan_q;
    logic [3:0]      an_q;
    logic [7:0]      seg_q;

    logic            en_s1_q, en_s2_q;
    logic [AW-1:0]   addr_s1_q, addr_s2_q;
    logic            half_s1_q, half_s2_q;

    // Two-flop synchronisers for the switch inputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_s1_q   <= 1'b0;
            en_s2_q   <= 1'b0;
            addr_s1_q <= '0;
            addr_s2_q <= '0;
            half_s1_q <= 1'b0;
            half_s2_q <= 1'b0;
        end else begin
            en_s1_q   <= dbg_en;
            en_s2_q   <= en_s1_q;
            addr_s1_q <= dbg_addr;
            addr_s2_q <= addr_s1_q;
            half_s1_q <= dbg_half;
            half_s2_q <= half_s1_q;
        end
    end

`ifdef DBG_STEP_EN
    logic step_s1_q, step_s2_q, step_s3_q;
    logic step_rise_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_s1_q <= 1'b0;
            step_s2_q <= 1'b0;
            step_s3_q <= 1'b0;
        end else begin
            step_s1_q <= step;
            step_s2_q <= step_s1_q;
            step_s3_q <= step_s2_q;
        end
    end

    assign step_rise_c = step_s2_q & ~step_s3_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            halt_q     <= 1'b0;
            cap_addr_q <= '0;
            lat_q      <= '0;
            word_q     <= '0;
        end else begin
            state_q    <= state_d;
            halt_q     <= halt_d;
            cap_addr_q <= cap_addr_d;
            lat_q      <= lat_d;
            word_q     <= word_d;
        end
    end

    // Next-state logic; a dbg_en drop always wins over any other event
    always_comb begin
        state_d    = state_q;
        halt_d     = 1'b0;
        cap_addr_d = cap_addr_q;
        lat_d      = lat_q;
        word_d     = word_q;
        case (state_q)
            S_IDLE: begin
                if (en_s2_q) begin
                    state_d = S_DRAIN;
                    halt_d  = 1'b1;
                end
            end
            S_DRAIN: begin
                halt_d = 1'b1;
                if (!en_s2_q) begin
                    state_d = S_IDLE;
                    halt_d  = 1'b0;
                end else if (cpu_idle) begin
                    cap_addr_d = addr_s2_q;
                    lat_d      = LW'(READ_LAT);
                    state_d    = S_READ;
                end
            end
            S_READ: begin
                halt_d = 1'b1;
                if (!en_s2_q) begin
                    state_d = S_IDLE;
                    halt_d  = 1'b0;
                end else if (lat_q == '0) begin
                    word_d  = mem_rdata;
                    state_d = S_HOLD;
                end else begin
                    lat_d = lat_q - LW'(1);
                end
            end
            S_HOLD: begin
                halt_d = 1'b1;
                if (!en_s2_q) begin
                    state_d = S_IDLE;
                    halt_d  = 1'b0;
`ifdef DBG_STEP_EN
                end else if (step_rise_c) begin
                    // Release the CPU for one cycle, then drain and re-read
                    state_d = S_DRAIN;
                    halt_d  = 1'b0;
`endif
                end else if (addr_s2_q != cap_addr_q) begin
                    cap_addr_d = addr_s2_q;
                    lat_d      = LW'(READ_LAT);
                    state_d    = S_READ;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign cpu_halt = halt_q;
    assign mem_addr = (state_q == S_READ || state_q == S_HOLD) ? cap_addr_q : cpu_addr;

    function automatic logic [6:0] hex_seg(input logic [3:0] n);
        case (n)
            4'h0: hex_seg = 7'h40;
            4'h1: hex_seg = 7'h79;
            4'h2: hex_seg = 7'h24;
            4'h3: hex_seg = 7'h30;
            4'h4: hex_seg = 7'h19;
            4'h5: hex_seg = 7'h12;
            4'h6: hex_seg = 7'h02;
            4'h7: hex_seg = 7'h78;
            4'h8: hex_seg = 7'h00;
            4'h9: hex_seg = 7'h10;
            4'hA: hex_seg = 7'h08;
            4'hB: hex_seg = 7'h03;
            4'hC: hex_seg = 7'h46;
            4'hD: hex_seg = 7'h21;
            4'hE: hex_seg = 7'h06;
            default: hex_seg = 7'h0E;
        endcase
    endfunction

    logic [1:0]  digit_c;
    logic [15:0] shown_c;
    logic [3:0]  nib_c;
    logic        dp_c;

    // Display mux: debug word in READ/HOLD, CPU status otherwise
    always_comb begin
        digit_c = scan_q[SCAN_W-1 -: 2];
        if (state_q == S_READ || state_q == S_HOLD) begin
            shown_c = half_s2_q ? word_q[31:16] : word_q[15:0];
        end else begin
            shown_c = cpu_disp;
        end
        nib_c = shown_c[{digit_c, 2'b00} +: 4];
        dp_c  = ~((state_q == S_HOLD) && half_s2_q && (digit_c == 2'd0));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_q <= '0;
            an_q   <= 4'b1110;
            seg_q  <= 8'hFF;
        end else begin
            scan_q <= scan_q + SCAN_W'(1);
            an_q   <= ~(4'b0001 << digit_c);
            seg_q  <= {dp_c, hex_seg(nib_c)};
        end
    end

    assign an  = an_q;
    assign seg = seg_q;

endmodule

// File: tb/tb_dbg_view_ctrl.sv
// Directed self-checking bench for dbg_view_ctrl with a registered 1-cycle memory model.
module tb_dbg_view_ctrl;

    localparam int unsigned AW = 7;
    localparam int unsigned RL = 1;
    localparam int unsigned SW = 4;
    localparam logic [AW-1:0] CPU_A = 7'h33;

    logic          clk;
    logic          rst_n;
    logic          step;
    logic          dbg_en;
    logic [AW-1:0] dbg_addr;
    logic          dbg_half;
    logic [AW-1:0] cpu_addr;
    logic          cpu_idle;
    logic [15:0]   cpu_disp;
    logic          cpu_halt;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_rdata;
    logic [3:0]    an;
    logic [7:0]    seg;

    logic [31:0] mem [0:127];

    int checks = 0;
    int errors = 0;

    dbg_view_ctrl #(.AW(AW), .READ_LAT(RL), .SCAN_W(SW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef DBG_STEP_EN
        .step      (step),
`endif
        .dbg_en    (dbg_en),
        .dbg_addr  (dbg_addr),
        .dbg_half  (dbg_half),
        .cpu_addr  (cpu_addr),
        .cpu_idle  (cpu_idle),
        .cpu_disp  (cpu_disp),
        .cpu_halt  (cpu_halt),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .an        (an),
        .seg       (seg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) mem_rdata <= mem[mem_addr];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] hexseg(input logic [3:0] n);
        case (n)
            4'h0: hexseg = 7'h40; 4'h1: hexseg = 7'h79; 4'h2: hexseg = 7'h24; 4'h3: hexseg = 7'h30;
            4'h4: hexseg = 7'h19; 4'h5: hexseg = 7'h12; 4'h6: hexseg = 7'h02; 4'h7: hexseg = 7'h78;
            4'h8: hexseg = 7'h00; 4'h9: hexseg = 7'h10; 4'hA: hexseg = 7'h08; 4'hB: hexseg = 7'h03;
            4'hC: hexseg = 7'h46; 4'hD: hexseg = 7'h21; 4'hE: hexseg = 7'h06; default: hexseg = 7'h0E;
        endcase
    endfunction

    // Expected {d3,d2,d1,d0} segment bytes; dp_on lights dp on digit 0
    function automatic logic [31:0] exp_disp(input logic [15:0] v, input logic dp_on);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) begin
            r[i*8 +: 8] = {((i == 0) ? ~dp_on : 1'b1), hexseg(v[i*4 +: 4])};
        end
        return r;
    endfunction

    // Watch one full scan (bounded) and record each digit's segments
    task automatic grab(output logic [31:0] d, output logic ok);
        logic [3:0] seen;
        seen = 4'b0000;
        d    = '0;
        for (int i = 0; i < 20; i++) begin
            tick();
            case (an)
                4'b1110: begin d[7:0]   = seg; seen[0] = 1'b1; end
                4'b1101: begin d[15:8]  = seg; seen[1] = 1'b1; end
                4'b1011: begin d[23:16] = seg; seen[2] = 1'b1; end
                4'b0111: begin d[31:24] = seg; seen[3] = 1'b1; end
                default: ;
            endcase
        end
        ok = &seen;
    endtask

    task automatic test_reset();
        dbg_en = 1'b1;
        rst_n  = 1'b0;
        repeat (5) tick();
        checks++;
        if (cpu_halt !== 1'b0 || mem_addr !== CPU_A) begin
            errors++;
            $display("FAIL reset_outputs: halt=%b mem_addr=%h, want halt=0 mem_addr=%h", cpu_halt, mem_addr, CPU_A);
        end
        checks++;
        if (an !== 4'b1110 || seg !== 8'hFF) begin
            errors++;
            $display("FAIL reset_display: an=%b seg=%h, want an=1110 seg=ff", an, seg);
        end
        rst_n = 1'b1;
        tick(); tick();
        checks++;
        if (cpu_halt !== 1'b0) begin
            errors++;
            $display("FAIL reset_halt_early: halt=%b, want 0 after 2 cycles", cpu_halt);
        end
        tick();
        checks++;
        if (cpu_halt !== 1'b1) begin
            errors++;
            $display("FAIL reset_halt_rise: halt=%b, want 1 after 3 cycles", cpu_halt);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (cpu_halt !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: halt=%b, want 0 right after rst_n fall", cpu_halt);
        end
        dbg_en = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (4) tick();
    endtask

    task automatic test_basic_read();
        logic [31:0] d;
        logic        ok;
        cpu_idle = 1'b1;
        dbg_addr = 7'd5;
        dbg_half = 1'b0;
        dbg_en   = 1'b1;
        tick(); tick();
        checks++;
        if (cpu_halt !== 1'b0) begin
            errors++;
            $display("FAIL basic_halt_early: halt=%b, want 0", cpu_halt);
        end
        tick();
        checks++;
        if (cpu_halt !== 1'b1 || mem_addr !== CPU_A) begin
            errors++;
            $display("FAIL basic_drain: halt=%b mem_addr=%h, want 1 / %h", cpu_halt, mem_addr, CPU_A);
        end
        tick();
        checks++;
        if (mem_addr !== 7'd5) begin
            errors++;
            $display("FAIL basic_read_addr: mem_addr=%h, want 05", mem_addr);
        end
        repeat (6) tick();
        grab(d, ok);
        checks++;
        if (!ok || d !== 32'h8386868E) begin
            errors++;
            $display("FAIL basic_low_half: seen=%b digits=%h, want 8386868e", ok, d);
        end
        dbg_half = 1'b1;
        repeat (4) tick();
        grab(d, ok);
        checks++;
        if (!ok || d !== 32'hA1868821) begin
            errors++;
            $display("FAIL basic_high_half: seen=%b digits=%h, want a1868821", ok, d);
        end
        dbg_half = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_exit_hold();
        logic [31:0] d;
        logic        ok;
        dbg_en = 1'b0;
        tick(); tick();
        checks++;
        if (cpu_halt !== 1'b1) begin
            errors++;
            $display("FAIL exit_halt_early: halt=%b, want 1", cpu_halt);
        end
        tick();
        checks++;
        if (cpu_halt !== 1'b0 || mem_addr !== CPU_A) begin
            errors++;
            $display("FAIL exit_release: halt=%b mem_addr=%h, want 0 / %h", cpu_halt, mem_addr, CPU_A);
        end
        repeat (3) tick();
        grab(d, ok);
        checks++;
        if (!ok || d !== 32'hC0C099C0) begin
            errors++;
            $display("FAIL exit_cpu_disp: seen=%b digits=%h, want c0c099c0", ok, d);
        end
    endtask

    task automatic test_drain_wait();
        logic [31:0] d;
        logic        ok;
        int          bad;
        cpu_idle = 1'b0;
        dbg_addr = 7'd5;
        dbg_en   = 1'b1;
        repeat (3) tick();
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (cpu_halt !== 1'b1 || mem_addr !== CPU_A) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL drain_hold_port: %0d bad cycles (halt=%b mem_addr=%h), want 0", bad, cpu_halt, mem_addr);
        end
        grab(d, ok);
        checks++;
        if (!ok || d !== 32'hC0C099C0) begin
            errors++;
            $display("FAIL drain_no_capture: seen=%b digits=%h, want c0c099c0", ok, d);
        end
        cpu_idle = 1'b1;
        tick();
        checks++;
        if (mem_addr !== 7'd5) begin
            errors++;
            $display("FAIL drain_exit_addr: mem_addr=%h, want 05", mem_addr);
        end
        repeat (6) tick();
        grab(d, ok);
        checks++;
        if (!ok || d !== 32'h8386868E) begin
            errors++;
            $display("FAIL drain_capture: seen=%b digits=%h, want 8386868e", ok, d);
        end
    endtask

    task automatic test_addr_walk();
        logic [31:0] d;
        logic        ok;
        int          bad;
        logic [31:0] want;
        for (int a = 1; a <= 5; a++) begin
            dbg_addr = AW'(a);
            bad = 0;
            for (int i = 0; i < 10; i++) begin
                tick();
                if (cpu_halt !== 1'b1 || mem_addr === CPU_A) bad++;
            end
            checks++;
            if (bad != 0 || mem_addr !== AW'(a)) begin
                errors++;
                $display("FAIL walk_addr_%0d: bad=%0d mem_addr=%h halt=%b, want 0 / %h / 1", a, bad, mem_addr, cpu_halt, AW'(a));
            end
            want = exp_disp(mem[a][15:0], 1'b0);
            grab(d, ok);
            checks++;
            if (!ok || d !== want) begin
                errors++;
                $display("FAIL walk_word_%0d: seen=%b digits=%h, want %h", a, ok, d, want);
            end
        end
    endtask

    task automatic test_abort_read();
        dbg_addr = 7'd2;
        tick();
        dbg_en = 1'b0;
        tick(); tick();
        checks++;
        if (mem_addr !== 7'd2 || cpu_halt !== 1'b1) begin
            errors++;
            $display("FAIL abort_in_read: mem_addr=%h halt=%b, want 02 / 1", mem_addr, cpu_halt);
        end
        tick();
        checks++;
        if (mem_addr !== CPU_A || cpu_halt !== 1'b0) begin
            errors++;
            $display("FAIL abort_release: mem_addr=%h halt=%b, want %h / 0", mem_addr, cpu_halt, CPU_A);
        end
        repeat (4) tick();
        checks++;
        if (dut.word_q !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL abort_word_kept: word=%h, want deadbeef", dut.word_q);
        end
    endtask

`ifdef DBG_STEP_EN
    task automatic test_step();
        logic [31:0] d;
        logic        ok;
        int          lows;
        dbg_addr = 7'd5;
        dbg_en   = 1'b1;
        repeat (12) tick();
        mem[5] = 32'h0000CAFE;
        step = 1'b1;
        lows = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (i == 1) step = 1'b0;
            if (cpu_halt === 1'b0) lows++;
        end
        checks++;
        if (lows != 1) begin
            errors++;
            $display("FAIL step_release: halt low %0d cycles, want 1", lows);
        end
        grab(d, ok);
        checks++;
        if (!ok || d !== 32'hC6888E86) begin
            errors++;
            $display("FAIL step_reread: seen=%b digits=%h, want c6888e86", ok, d);
        end
    endtask
`endif

    initial begin
        rst_n    = 1'b0;
        step     = 1'b0;
        dbg_en   = 1'b0;
        dbg_addr = '0;
        dbg_half = 1'b0;
        cpu_addr = CPU_A;
        cpu_idle = 1'b1;
        cpu_disp = 16'h0040;
        for (int i = 0; i < 128; i++) mem[i] = 32'h0;
        mem[1]  = 32'hAAAA1234;
        mem[2]  = 32'hBBBB5678;
        mem[3]  = 32'hCCCC9ABC;
        mem[4]  = 32'hDDDDCDEF;
        mem[5]  = 32'hDEADBEEF;
        mem[51] = 32'h11111111;

        test_reset();
        test_basic_read();
        test_exit_hold();
        test_drain_wait();
        test_addr_walk();
        test_abort_read();
`ifdef DBG_STEP_EN
        test_step();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
